// File: rtl/random_tile_gen.sv
// Seedable 16-bit Galois LFSR plus a spawn FSM that picks a random empty board
// cell (rejection sampling, then a linear scan fallback) and a 2/4 tile value.
module random_tile_gen #(
  parameter int                CELLS       = 16,
  parameter int                IDX_W       = 4,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                FOUR_THRESH = 2,
  parameter int                MAX_TRIES   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  input  logic [CELLS-1:0]  empty_mask,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [IDX_W-1:0]  cell_idx,
  output logic              tile_is4
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

  typedef enum logic [2:0] {IDLE, SAMPLE, SCAN, FULL, DONE} state_t;

  state_t              state, state_d;
  logic [LFSR_W-1:0]   lfsr, lfsr_next;
  logic [CELLS-1:0]    mask_q, mask_d;
  logic [TRY_W-1:0]    tries, tries_d;
  logic [IDX_W-1:0]    ptr, ptr_d;
  logic [IDX_W-1:0]    idx_d;
  logic                is4_d, valid_d;
  logic [IDX_W-1:0]    cand;
  logic [2**IDX_W-1:0] mask_ext;
  logic                tile4;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign cand      = lfsr[IDX_W-1:0];
  assign tile4     = {28'b0, lfsr[LFSR_W-1:LFSR_W-4]} < 32'(FOUR_THRESH);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Indices at or above CELLS read as occupied through the zero padding.
  always_comb begin
    mask_ext = '0;
    mask_ext[CELLS-1:0] = mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= (seed_in == '0) ? SEED : seed_in;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mask_q   <= '0;
      tries    <= '0;
      ptr      <= '0;
      cell_idx <= '0;
      tile_is4 <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state    <= state_d;
      mask_q   <= mask_d;
      tries    <= tries_d;
      ptr      <= ptr_d;
      cell_idx <= idx_d;
      tile_is4 <= is4_d;
      valid    <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    tries_d = tries;
    ptr_d   = ptr;
    idx_d   = cell_idx;
    is4_d   = tile_is4;
    valid_d = valid;
    case (state)
      IDLE: begin
        if (req) begin
          mask_d  = empty_mask;
          tries_d = '0;
          state_d = (empty_mask == '0) ? FULL : SAMPLE;
        end
      end
      SAMPLE: begin
        if (mask_ext[cand]) begin
          idx_d   = cand;
          is4_d   = tile4;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          tries_d = tries + 1'b1;
          if (tries == TRY_W'(MAX_TRIES - 1)) begin
            ptr_d   = cand;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (mask_ext[ptr]) begin
          idx_d   = ptr;
          is4_d   = tile4;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d = (int'(ptr) + 1 >= CELLS) ? '0 : ptr + 1'b1;
        end
      end
      FULL: begin
        valid_d = 1'b0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/random_tile_gen.md
Name: random_tile_gen

Overview:
Parametrised successor to the free-running 4-bit random number source. It holds a seedable LFSR and, on request, picks a uniformly random empty cell from a board occupancy mask. It also chooses the new tile value: 2, or 4 with programmable probability. It sits between the 2048 move/merge engine and the board register file and spawns one tile after each valid move.

Parameters:
CELLS, 16, number of board cells (2..64).
IDX_W, 4, cell index width; 2^IDX_W >= CELLS.
LFSR_W, 16, LFSR width (16 only; taps fixed).
SEED, 16'hACE1, reset/zero-substitute seed.
FOUR_THRESH, 2, tile is 4 when LFSR[15:12] < FOUR_THRESH (probability FOUR_THRESH/16).
MAX_TRIES, 32, rejection-sampling attempts before fallback scan.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
seed_load  in  1  load seed_in into LFSR this edge.
seed_in  in  LFSR_W  seed value; 0 substituted by SEED.
req  in  1  spawn request, sampled in IDLE only.
empty_mask  in  CELLS  bit i=1 means cell i empty; latched on accepted req.
busy  out  1  high while FSM not IDLE.
done  out  1  one-cycle pulse, result valid.
valid  out  1  1 = cell found; 0 = board full.
cell_idx  out  IDX_W  chosen cell.
tile_is4  out  1  0 = tile 2, 1 = tile 4.

Behaviour:
- Reset (async, rst_n=0): LFSR=SEED, state=IDLE, busy=0, done=0, valid=0, cell_idx=0, tile_is4=0, try counter=0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It advances every clock, regardless of FSM state. It never holds 0.
- seed_load: LFSR <= (seed_in==0 ? SEED : seed_in). This has priority over the advance. It is allowed in any state; the FSM continues using the new stream.
- States:
  - IDLE: on req, latch mask into mask_q and clear tries. If mask_q==0 go to FULL, else go to SAMPLE.
  - SAMPLE: each cycle, cand = LFSR[IDX_W-1:0].
    - If cand < CELLS and mask_q[cand], accept: cell_idx<=cand, tile_is4<=(LFSR[15:12]<FOUR_THRESH), go to DONE.
    - Otherwise tries++. When tries reaches MAX_TRIES, ptr<=cand mod 2^IDX_W and go to SCAN.
  - SCAN: examine mask_q[ptr] (ptr>=CELLS counts as occupied).
    - On hit, accept as in SAMPLE.
    - Otherwise ptr<=(ptr+1==CELLS or ptr>=CELLS) ? 0 : ptr+1.
    - A hit is guaranteed within 2^IDX_W cycles.
  - FULL: valid<=0, go to DONE.
  - DONE: done=1 for exactly one cycle, valid=1 unless arriving from FULL, then IDLE.
- busy=1 in every state except IDLE.
- Latency from the req edge to done high:
  - full board: 2 cycles;
  - first-try hit: 2 cycles;
  - worst case: MAX_TRIES + 2^IDX_W + 2 cycles.
- valid, cell_idx and tile_is4 hold their values from done until the next done.
- req while busy is ignored and not queued. req high continuously starts a new spawn each time the FSM returns to IDLE.
- empty_mask changes after the req edge have no effect on the current spawn.
- Reset mid-operation returns to IDLE immediately. No done is issued and the outputs return to their reset values.
- With the same seed and the same req/mask sequence, outputs are bit-identical across runs (deterministic).

Test Plan:
- Reset, then req with empty_mask=16'h0000 -> done 2 cycles later, valid=0, busy high for 2 cycles.
- empty_mask=16'h0020 (cell 5 only), 50 reqs -> every done has valid=1 and cell_idx=5, each within MAX_TRIES+18 cycles.
- empty_mask=16'hFFFF, 2000 reqs -> all valid=1; every cell index 0..15 seen; tile_is4 count between 170 and 330 (expected 250).
- seed_load with seed_in=0, then 10 reqs on mask 16'h00FF; repeat with seed_in=16'hACE1 -> identical cell_idx/tile_is4 sequences, all cell_idx<8.
- req pulsed again while busy, and empty_mask changed to 0 one cycle after req -> exactly one done; result drawn from the original mask.
- Assert rst_n low during SAMPLE -> busy=0, done never pulses; a subsequent req completes normally.
- CELLS=9, IDX_W=4 build, mask=9'h100 -> cell_idx=8 always, never >=9.
